// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants and types for the RGB PWM LED driver.
// Colour word layout: [23:16]=R, [15:8]=G, [7:0]=B.
package rgb_pwm_driver_pkg;

    localparam int RES_DEF = 8;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    localparam logic [7:0] FULL_ON = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM output channel: registered compare of the period counter
// against an 8-bit duty, with a full-on override for duty 8'hFF.
module pwm_channel
    import rgb_pwm_driver_pkg::*;
#(
    parameter int RES = RES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [RES-1:0] pwm_cnt,
    input  logic [7:0]     duty,
    output logic           led
);

    localparam int W = (RES > 8) ? RES : 8;

    logic [W-1:0] cnt_w;
    logic [W-1:0] duty_w;
    logic         led_d;
    logic         led_q;

    assign cnt_w  = W'(pwm_cnt);
    assign duty_w = W'(duty);
    assign led_d  = en && ((duty == FULL_ON) || (cnt_w < duty_w));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: prescaler, period counter, boundary-loaded colour
// shadow, period-start pulse and three PWM channels.
module rgb_pwm_driver
    import rgb_pwm_driver_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int RES      = RES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] light,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        pstart
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [RES-1:0] CNT_MAX = '1;

    logic [PW-1:0]  pre_cnt_q;
    logic [PW-1:0]  pre_cnt_d;
    logic [RES-1:0] pwm_cnt_q;
    logic [RES-1:0] pwm_cnt_d;
    logic [23:0]    shadow_q;
    logic [23:0]    shadow_d;
    logic           tick;
    logic           boundary;
    state_e         state_q;
    logic           pstart_q;

    assign tick     = (pre_cnt_q == PRE_MAX);
    assign boundary = tick && (pwm_cnt_q == CNT_MAX);

    // Disabled: counters park at zero and the shadow tracks the input,
    // so the first enabled period starts clean with the current colour.
    always_comb begin
        pre_cnt_d = '0;
        pwm_cnt_d = '0;
        shadow_d  = shadow_q;
        if (!en) begin
            shadow_d = light;
        end else begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
            pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
            if (boundary) begin
                shadow_d = light;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            shadow_q  <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            shadow_q  <= shadow_d;
        end
    end

    // In IDLE the counters are already zero, so enabling starts a period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pstart_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pstart_q <= en;
                    if (en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    pstart_q <= en && (pwm_cnt_q == '0) && (pre_cnt_q == '0);
                    if (!en) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign pstart = pstart_q;

    pwm_channel #(.RES(RES)) u_ch_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pwm_cnt (pwm_cnt_q),
        .duty    (shadow_q[R_HI:R_LO]),
        .led     (led_r)
    );

    pwm_channel #(.RES(RES)) u_ch_g (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pwm_cnt (pwm_cnt_q),
        .duty    (shadow_q[G_HI:G_LO]),
        .led     (led_g)
    );

    pwm_channel #(.RES(RES)) u_ch_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pwm_cnt (pwm_cnt_q),
        .duty    (shadow_q[B_HI:B_LO]),
        .led     (led_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver at PRESCALE=1 (256-cycle period): per-period
// high counts are queued by the stimulus and checked at each pstart.
module tb_rgb_pwm_driver;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic [23:0] light = 24'h0;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        pstart;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int r;
        int g;
        int b;
        int len;
    } per_t;

    typedef struct {
        logic [23:0] l;
        int          r;
        int          g;
        int          b;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV] = '{
        '{24'h808080, 128, 128, 128},
        '{24'hFFFFFF, 256, 256, 256},
        '{24'hFFFFFF, 256, 256, 256},
        '{24'hFFFFFF, 256, 256, 256},
        '{24'hFFFFFF, 256, 256, 256},
        '{24'h0000FF,   0,   0, 256},
        '{24'h408000,  64, 128,   0},
        '{24'h408000,  64, 128,   0},
        '{24'h000010,   0,   0,  16},
        '{24'h0000F0,   0,   0, 240},
        '{24'h404040,  64,  64,  64}
    };

    per_t exp_q [$];
    int   abort_req  = 0;
    int   abort_seen = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(
        .PRESCALE (1),
        .RES      (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .light  (light),
        .led_r  (led_r),
        .led_g  (led_g),
        .led_b  (led_b),
        .pstart (pstart)
    );

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_per(input per_t e, input int len,
                             input int r, input int g, input int b);
        n_tests++;
        if (e.len != len || e.r != r || e.g != g || e.b != b) begin
            n_fail++;
            $display("FAIL period: got len=%0d r=%0d g=%0d b=%0d, want len=%0d r=%0d g=%0d b=%0d",
                     len, r, g, b, e.len, e.r, e.g, e.b);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_pstart(input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!pstart && k < 300);
        if (!pstart) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic mon_loop();
        bit   in_p;
        int   len;
        int   r;
        int   g;
        int   b;
        per_t e;
        in_p = 1'b0;
        len  = 0;
        r    = 0;
        g    = 0;
        b    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || abort_req != abort_seen) begin
                abort_seen = abort_req;
                in_p = 1'b0;
            end else if (pstart) begin
                if (in_p) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_period", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_per(e, len, r, g, b);
                    end
                end
                in_p = 1'b1;
                len  = 1;
                r    = int'(led_r);
                g    = int'(led_g);
                b    = int'(led_b);
            end else if (in_p) begin
                len++;
                r += int'(led_r);
                g += int'(led_g);
                b += int'(led_b);
            end
        end
    endtask

    initial begin
        int seen;
        fork
            mon_loop();
        join_none

        step(3);
        check("rst_leds", int'({led_r, led_g, led_b}), 0);
        check("rst_pstart", int'(pstart), 0);

        rst_n = 1'b1;
        light = 24'h808080;
        step(1);
        en = 1'b1;
        step(100);
        check("run_led_r", int'(led_r), 1);

        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("async_rst_leds", int'({led_r, led_g, led_b}), 0);
        check("async_rst_pstart", int'(pstart), 0);

        step(260);
        rst_n = 1'b1;
        step(2);
        check("idle_outputs", int'({pstart, led_r, led_g, led_b}), 0);
        en = 1'b1;
        step(1);
        check("en_pstart", int'(pstart), 1);

        for (int i = 0; i < NV; i++) begin
            exp_q.push_back('{vecs[i].r, vecs[i].g, vecs[i].b, 256});
            step(50);
            if (i < NV - 1) light = vecs[i + 1].l;
            wait_pstart("period");
        end

        step(19);
        check("pre_drop_leds", int'({led_r, led_g, led_b}), 7);
        abort_req++;
        en = 1'b0;
        step(1);
        check("drop_leds", int'({led_r, led_g, led_b}), 0);
        check("drop_pstart", int'(pstart), 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen += int'(pstart);
        end
        check("off_pstart", seen, 0);

        exp_q.push_back('{64, 64, 64, 256});
        en = 1'b1;
        step(1);
        check("reen_pstart", int'(pstart), 1);
        wait_pstart("reen");
        step(1);
        abort_req++;
        en = 1'b0;
        step(3);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
